seq_restoring_divider: RTL

//  Multi-cycle unsigned restoring divider, the inverse path to the 6x6 approximate multiplier.

---
 rtl/div_pkg.sv | 12 +
 rtl/div_trial_sub.sv | 18 +
 rtl/seq_restoring_divider.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared widths and state encodings for the sequential restoring divider.
package div_pkg;

   localparam int unsigned DW = 12;
   localparam int unsigned VW = 6;
   localparam int unsigned CW = $clog2(DW);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/div_trial_sub.sv
// Trial subtraction r_shifted - divisor over VW+1 bits, built as a + ~b + 1.
module div_trial_sub
   import div_pkg::*;
(
   input  logic [VW:0]   r_shifted,
   input  logic [VW-1:0] divisor,
   output logic [VW:0]   diff,
   output logic          borrow
);

   logic [VW+1:0] sum;

   // The carry out of a + ~b + 1 is set exactly when a >= b.
   assign sum    = {1'b0, r_shifted} + {1'b0, ~{1'b0, divisor}} + (VW+2)'(1);
   assign diff   = sum[VW:0];
   assign borrow = ~sum[VW+1];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Macro DIV_REMAINDER_EN enables the remainder output; otherwise rem is tied to 0.
module seq_restoring_divider
   import div_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] quot,
   output logic [VW-1:0] rem,
   output logic          dz
);

   logic [1:0]    state, state_n;
   logic [DW-1:0] d, d_n;
   logic [DW-1:0] q, q_n;
   logic [VW:0]   r, r_n;
   logic [VW-1:0] v, v_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          dzf, dzf_n;
   logic          busy_n, done_n, dz_n;
   logic [DW-1:0] quot_n;
   logic [VW:0]   r_shifted;
   logic [VW:0]   diff;
   logic          borrow;

   // The restored remainder always fits VW bits, so its top bit is dropped by the cast.
   assign r_shifted = (VW+1)'({r, d[DW-1]});

   div_trial_sub u_trial_sub (
      .r_shifted (r_shifted),
      .divisor   (v),
      .diff      (diff),
      .borrow    (borrow)
   );

`ifdef DIV_REMAINDER_EN
   logic [VW-1:0] rem_q, rem_n;
   assign rem = rem_q;
`else
   assign rem = '0;
`endif

   // Next-state, datapath and output register inputs.
   always_comb begin
      state_n = state;
      d_n     = d;
      q_n     = q;
      r_n     = r;
      v_n     = v;
      cnt_n   = cnt;
      dzf_n   = dzf;
      done_n  = 1'b0;
      quot_n  = quot;
      dz_n    = dz;
`ifdef DIV_REMAINDER_EN
      rem_n   = rem_q;
`endif
      case (state)
         ST_IDLE: begin
            // busy still covers the done cycle, so a start there is ignored.
            if (start && !busy) begin
               quot_n = '0;
               dz_n   = 1'b0;
`ifdef DIV_REMAINDER_EN
               rem_n  = '0;
`endif
               d_n    = dividend;
               v_n    = divisor;
               r_n    = '0;
               q_n    = '0;
               cnt_n  = CW'(DW - 1);
               dzf_n  = 1'b0;
               if (divisor == '0) begin
                  q_n     = '1;
                  dzf_n   = 1'b1;
                  state_n = ST_DONE;
               end else begin
                  state_n = ST_CALC;
               end
            end
         end
         ST_CALC: begin
            d_n = {d[DW-2:0], 1'b0};
            r_n = borrow ? r_shifted : diff;
            q_n = {q[DW-2:0], ~borrow};
            if (cnt == '0) begin
               state_n = ST_DONE;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         ST_DONE: begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
            quot_n  = q;
            dz_n    = dzf;
`ifdef DIV_REMAINDER_EN
            rem_n   = r[VW-1:0];
`endif
         end
         default: state_n = ST_IDLE;
      endcase
      busy_n = (state_n != ST_IDLE) || (state == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         d     <= '0;
         q     <= '0;
         r     <= '0;
         v     <= '0;
         cnt   <= '0;
         dzf   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         quot  <= '0;
         dz    <= 1'b0;
`ifdef DIV_REMAINDER_EN
         rem_q <= '0;
`endif
      end else begin
         state <= state_n;
         d     <= d_n;
         q     <= q_n;
         r     <= r_n;
         v     <= v_n;
         cnt   <= cnt_n;
         dzf   <= dzf_n;
         busy  <= busy_n;
         done  <= done_n;
         quot  <= quot_n;
         dz    <= dz_n;
`ifdef DIV_REMAINDER_EN
         rem_q <= rem_n;
`endif
      end
   end

endmodule
